// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of each complete PWM cycle
// in clk cycles and flags a line that stops toggling for CNT_MAX cycles.
module pwm_duty_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] period_acc;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_high;
    logic             cap_valid;

    assign rise = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A finished cycle is captured on its closing rise and published one clock
    // later, which keeps valid latency constant from the sampled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period_acc <= CNT_ZERO;
            high_acc   <= CNT_ZERO;
            cap_period <= CNT_ZERO;
            cap_high   <= CNT_ZERO;
            cap_valid  <= 1'b0;
            high_cnt   <= CNT_ZERO;
            period_cnt <= CNT_ZERO;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            cap_valid  <= 1'b0;
            meas_valid <= cap_valid & en;
            if (cap_valid && en) begin
                high_cnt   <= cap_high;
                period_cnt <= cap_period;
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end

            if (!en) begin
                state      <= IDLE;
                period_acc <= CNT_ZERO;
                high_acc   <= CNT_ZERO;
            end else begin
                case (state)
                    IDLE: begin
                        period_acc <= CNT_ZERO;
                        high_acc   <= CNT_ZERO;
                        state      <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            period_acc <= CNT_ONE;
                            high_acc   <= CNT_ONE;
                            state      <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // Rise wins over timeout so a period of exactly CNT_MAX is reported.
                        if (rise) begin
                            cap_period <= period_acc;
                            cap_high   <= high_acc;
                            cap_valid  <= 1'b1;
                            period_acc <= CNT_ONE;
                            high_acc   <= CNT_ONE;
                        end else if (period_acc == CNT_MAX) begin
                            stuck_high <= s2;
                            stuck_low  <= ~s2;
                            period_acc <= CNT_ZERO;
                            high_acc   <= CNT_ZERO;
                            state      <= ARM;
                        end else begin
                            period_acc <= period_acc + CNT_ONE;
                            if (s2) begin
                                high_acc <= high_acc + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: directed scenarios plus random
// waveforms, compared each cycle against an edge-timing reference model.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    logic en_level = 1'b0;

    // Level of pwm_in as sampled at each rising clk edge, indexed by edge.
    bit q_hist [0:65535];

    logic             exp_valid  = 1'b0;
    logic [CNT_W-1:0] exp_high   = '0;
    logic [CNT_W-1:0] exp_period = '0;
    logic             exp_sh     = 1'b0;
    logic             exp_sl     = 1'b0;

    bit m_idle   = 1'b1;
    bit m_armed  = 1'b0;
    bit m_pend   = 1'b0;
    int m_start  = -1;
    int m_pend_p = 0;
    int m_pend_h = 0;

    pwm_duty_meter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    function automatic bit q_at(input int i);
        return (i < 0) ? 1'b0 : q_hist[i];
    endfunction

    // A rising sample at edge k is acted on by the meter at edge k+2.
    function automatic bit rise_seen(input int t);
        return q_at(t - 2) && !q_at(t - 3);
    endfunction

    function automatic int count_high(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(q_at(i));
        return c;
    endfunction

    function automatic void model_edge(input logic e, input logic r);
        int t = n;
        if (r) begin
            for (int i = 0; i < 3; i++) if (t - i >= 0) q_hist[t - i] = 1'b0;
            exp_valid = 1'b0; exp_high = '0; exp_period = '0;
            exp_sh = 1'b0; exp_sl = 1'b0;
            m_idle = 1'b1; m_armed = 1'b0; m_start = -1; m_pend = 1'b0;
        end else if (!e) begin
            exp_valid = 1'b0;
            m_idle = 1'b1; m_armed = 1'b0; m_start = -1; m_pend = 1'b0;
        end else begin
            exp_valid = m_pend;
            if (m_pend) begin
                exp_high   = CNT_W'(m_pend_h);
                exp_period = CNT_W'(m_pend_p);
                exp_sh = 1'b0; exp_sl = 1'b0;
            end
            m_pend = 1'b0;
            if (m_idle) begin
                m_idle = 1'b0; m_armed = 1'b1;
            end else if (m_armed) begin
                if (rise_seen(t)) begin
                    m_armed = 1'b0; m_start = t;
                end
            end else if (m_start >= 0) begin
                if (rise_seen(t)) begin
                    m_pend   = 1'b1;
                    m_pend_p = t - m_start;
                    m_pend_h = count_high(m_start - 2, t - 3);
                    m_start  = t;
                end else if (t - m_start == CNT_MAX) begin
                    exp_sh  = q_at(t - 2);
                    exp_sl  = !q_at(t - 2);
                    m_armed = 1'b1;
                    m_start = -1;
                end
            end
        end
    endfunction

    task automatic checkOutput();
        checks++;
        assert (meas_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL meas_valid edge=%0d got=%0b exp=%0b", n, meas_valid, exp_valid);
        end
        checks++;
        assert (high_cnt === exp_high) else begin
            errors++;
            $error("[TB] FAIL high_cnt edge=%0d got=%0d exp=%0d", n, high_cnt, exp_high);
        end
        checks++;
        assert (period_cnt === exp_period) else begin
            errors++;
            $error("[TB] FAIL period_cnt edge=%0d got=%0d exp=%0d", n, period_cnt, exp_period);
        end
        checks++;
        assert (stuck_high === exp_sh) else begin
            errors++;
            $error("[TB] FAIL stuck_high edge=%0d got=%0b exp=%0b", n, stuck_high, exp_sh);
        end
        checks++;
        assert (stuck_low === exp_sl) else begin
            errors++;
            $error("[TB] FAIL stuck_low edge=%0d got=%0b exp=%0b", n, stuck_low, exp_sl);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic e, input logic r);
        @(negedge clk);
        pwm_in = p;
        en     = e;
        rst    = r;
        @(posedge clk);
        q_hist[n] = p;
        model_edge(e, r);
        #1;
        checkOutput();
        n++;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic pwm_run(input int h, input int l, input int reps);
        for (int k = 0; k < reps; k++) begin
            for (int i = 0; i < h; i++) applyStimulus(1'b1, en_level, 1'b0);
            for (int i = 0; i < l; i++) applyStimulus(1'b0, en_level, 1'b0);
        end
    endtask

    task automatic hold(input logic lvl, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(lvl, en_level, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm_in = 1'b0;

        // Reset state, then periodic 5/16 waveform.
        do_reset(2);
        en_level = 1'b1;
        pwm_run(5, 11, 6);

        // Duty sweep at period 16, then 0% and 100% duty.
        for (int h = 1; h < 16; h++) pwm_run(h, 16 - h, 3);
        hold(1'b0, 300);
        pwm_run(3, 13, 3);
        hold(1'b1, 300);

        // Stuck-low and stuck-high after one rise, then cleared by valid data.
        pwm_run(1, 1, 1);
        hold(1'b0, 300);
        pwm_run(4, 6, 3);
        hold(1'b1, 300);
        pwm_run(3, 7, 3);

        // Boundary periods 255, 256 and 2.
        pwm_run(100, 155, 3);
        pwm_run(100, 156, 3);
        pwm_run(1, 1, 8);

        // Enable dropped mid-cycle, then restored.
        pwm_run(5, 11, 3);
        hold(1'b1, 3);
        en_level = 1'b0;
        hold(1'b1, 2);
        pwm_run(5, 11, 2);
        en_level = 1'b1;
        pwm_run(5, 11, 4);

        // Reset pulse during MEASURE while stuck_low is set.
        pwm_run(2, 2, 1);
        hold(1'b0, 300);
        pwm_run(6, 6, 1);
        hold(1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        hold(1'b1, 2);
        pwm_run(6, 10, 4);

        // Random waveforms with occasional long holds and enable drops.
        for (int seg = 0; seg < 60; seg++) begin
            int h, l, drop;
            h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 260)) : int'($urandom_range(1, 30));
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 260)) : int'($urandom_range(1, 30));
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, h + l)) : 0;
            for (int i = 0; i < h + l; i++) begin
                applyStimulus(i < h, !(drop != 0 && i >= drop / 2 && i < drop), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
